// File: rtl/sparse_arb_pkg.sv
// Shared types, token encodings and token classifiers for the sparse stream arbiter.
package sparse_arb_pkg;

  localparam int DATA_W = 17;

  localparam logic [DATA_W-1:0] DONE_TOKEN = 17'h10100;
  localparam logic [DATA_W-1:0] STOP_MASK  = 17'h10300;
  localparam logic [DATA_W-1:0] STOP_MATCH = 17'h10000;

  typedef enum logic [2:0] {
    IDLE,
    GRANT0,
    GRANT1,
    EMIT_DONE,
    FINISHED
  } arb_state_t;

  function automatic logic is_stop(input logic [DATA_W-1:0] data);
    return data[DATA_W-1] && ((data & STOP_MASK) == STOP_MATCH);
  endfunction

  function automatic logic is_done(input logic [DATA_W-1:0] data);
    return data == DONE_TOKEN;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the other requester when the
// current owner yields the port.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       flush,
  input  logic [1:0] req,
  input  logic       yield_valid,
  input  logic       yield_id,
  output logic       grant_valid,
  output logic       grant_id
);

  logic rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        rr_ptr <= 1'b0;
      end else if (yield_valid) begin
        rr_ptr <= ~yield_id;
      end
    end
  end

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant_valid = |req;
    grant_id    = (req == 2'b11) ? rr_ptr : req[1];
  end

endmodule

// File: rtl/sparse_stream_arbiter.sv
// Fiber-granular arbiter merging two sparse streams onto one ready/valid port.
// Optional performance counters are enabled with SPARSE_ARB_PERF_EN.
module sparse_stream_arbiter
  import sparse_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic [DATA_W-1:0] in_0,
  input  logic              in_0_valid,
  output logic              in_0_ready,
  input  logic [DATA_W-1:0] in_1,
  input  logic              in_1_valid,
  output logic              in_1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_src,
  output logic              done
`ifdef SPARSE_ARB_PERF_EN
  ,
  output logic [31:0]       busy_cycles,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       switch_count
`endif
);

  arb_state_t        state, state_next;
  logic [1:0]        retired, retired_next;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q, out_src_q;
  logic              out_free, out_fire;
  logic              sel_id, in_fire;
  logic [DATA_W-1:0] sel_data;
  logic              load_beat, load_done, done_held;
  logic [1:0]        req;
  logic              grant_valid, grant_id, yield_valid;

  assign out_fire   = tile_en & out_valid_q & out_ready;
  assign out_free   = ~out_valid_q | out_ready;
  assign in_0_ready = tile_en & clk_en & (state == GRANT0) & out_free;
  assign in_1_ready = tile_en & clk_en & (state == GRANT1) & out_free;
  assign sel_id     = (state == GRANT1);
  assign sel_data   = sel_id ? in_1 : in_0;
  assign in_fire    = sel_id ? (in_1_valid & in_1_ready) : (in_0_valid & in_0_ready);
  // Done tokens are never forwarded, so a held DONE_TOKEN is the merged one.
  assign done_held  = out_valid_q & is_done(out_data_q);
  assign req        = {in_1_valid & ~retired[1], in_0_valid & ~retired[0]}
                    & {2{tile_en & (state == IDLE)}};

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q & tile_en;
  assign out_src   = out_src_q;
  assign done      = (state == FINISHED);

  rr_arb2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .flush       (flush),
    .req         (req),
    .yield_valid (yield_valid),
    .yield_id    (sel_id),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_next   = state;
    retired_next = retired;
    load_beat    = 1'b0;
    load_done    = 1'b0;
    yield_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (retired == 2'b11) begin
          state_next = EMIT_DONE;
        end else if (grant_valid) begin
          state_next = grant_id ? GRANT1 : GRANT0;
        end
      end
      GRANT0, GRANT1: begin
        if (in_fire) begin
          if (is_done(sel_data)) begin
            retired_next[sel_id] = 1'b1;
            state_next           = IDLE;
          end else begin
            load_beat = 1'b1;
            if (is_stop(sel_data)) begin
              yield_valid = 1'b1;
              state_next  = IDLE;
            end
          end
        end
      end
      EMIT_DONE: begin
        if (done_held) begin
          if (out_fire) begin
            state_next = FINISHED;
          end
        end else if (tile_en & out_free) begin
          load_done = 1'b1;
        end
      end
      FINISHED: begin
        state_next = FINISHED;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      retired <= 2'b00;
    end else if (clk_en) begin
      if (flush) begin
        state   <= IDLE;
        retired <= 2'b00;
      end else begin
        state   <= state_next;
        retired <= retired_next;
      end
    end
  end

  // Single-entry output register; flush drops whatever it holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (load_beat) begin
        out_data_q  <= sel_data;
        out_src_q   <= sel_id;
        out_valid_q <= 1'b1;
      end else if (load_done) begin
        out_data_q  <= DONE_TOKEN;
        out_src_q   <= 1'b0;
        out_valid_q <= 1'b1;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef SPARSE_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cycles  <= '0;
      stall_cycles <= '0;
      switch_count <= '0;
    end else if (clk_en) begin
      if (flush) begin
        busy_cycles  <= '0;
        stall_cycles <= '0;
        switch_count <= '0;
      end else begin
        if (out_fire && (busy_cycles != '1)) begin
          busy_cycles <= busy_cycles + 32'd1;
        end
        if (out_valid && !out_ready && (stall_cycles != '1)) begin
          stall_cycles <= stall_cycles + 32'd1;
        end
        if (yield_valid && (switch_count != '1)) begin
          switch_count <= switch_count + 16'd1;
        end
      end
    end
  end
`endif

endmodule
